// File: rtl/alu_operand_stage.sv
// Single-entry ALU operand stage between decode and execute, with valid/ready handshake and flush.
// Optional operand bypass from MEM/WB compiled in with `define ALU_OPERAND_FORWARDING_EN.
module alu_operand_stage #(
    parameter int unsigned LENGTH   = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LENGTH-1:0]   in_rs1_val,
    input  logic [LENGTH-1:0]   in_rs2_val,
    input  logic [LENGTH-1:0]   in_imm,
    input  logic [REG_BITS-1:0] in_rs1,
    input  logic [REG_BITS-1:0] in_rs2,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                in_use_imm,
    input  logic                in_f,
    input  logic                in_wb_en,

    input  logic                flush,

    input  logic                fwd_mem_en,
    input  logic                fwd_wb_en,
    input  logic [REG_BITS-1:0] fwd_mem_rd,
    input  logic [REG_BITS-1:0] fwd_wb_rd,
    input  logic [LENGTH-1:0]   fwd_mem_data,
    input  logic [LENGTH-1:0]   fwd_wb_data,

    output logic [LENGTH-1:0]   alu_a,
    output logic [LENGTH-1:0]   alu_b,
    output logic                alu_f,
    output logic [REG_BITS-1:0] out_rd,
    output logic                out_wb_en,
    output logic                out_valid,
    input  logic                out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                w_accept;
    logic [LENGTH-1:0]   r_rs1_val;
    logic [LENGTH-1:0]   r_rs2_val;
    logic [LENGTH-1:0]   r_imm;
    logic [REG_BITS-1:0] r_rs1;
    logic [REG_BITS-1:0] r_rs2;
    logic [REG_BITS-1:0] r_rd;
    logic                r_use_imm;
    logic                r_f;
    logic                r_wb_en;
    logic [LENGTH-1:0]   w_rs1_opnd;
    logic [LENGTH-1:0]   w_rs2_opnd;

    assign out_valid = (r_state == FULL);
    assign in_ready  = (!out_valid || out_ready) && !flush;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Flush wins over everything; a stalled FULL entry simply stays put.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: if (w_accept) w_next = FULL;
                FULL:  if (out_ready && !w_accept) w_next = EMPTY;
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_use_imm <= 1'b0;
            r_f       <= 1'b0;
            r_wb_en   <= 1'b0;
        end else if (w_accept) begin
            r_rs1_val <= in_rs1_val;
            r_rs2_val <= in_rs2_val;
            r_imm     <= in_imm;
            r_rs1     <= in_rs1;
            r_rs2     <= in_rs2;
            r_rd      <= in_rd;
            r_use_imm <= in_use_imm;
            r_f       <= in_f;
            r_wb_en   <= in_wb_en;
        end
    end

`ifdef ALU_OPERAND_FORWARDING_EN
    // Bypass looks at the held indices every cycle so a stalled entry sees late results.
    always_comb begin
        w_rs1_opnd = r_rs1_val;
        if (r_rs1 != '0 && fwd_mem_en && fwd_mem_rd == r_rs1) begin
            w_rs1_opnd = fwd_mem_data;
        end else if (r_rs1 != '0 && fwd_wb_en && fwd_wb_rd == r_rs1) begin
            w_rs1_opnd = fwd_wb_data;
        end
    end

    always_comb begin
        w_rs2_opnd = r_rs2_val;
        if (r_rs2 != '0 && fwd_mem_en && fwd_mem_rd == r_rs2) begin
            w_rs2_opnd = fwd_mem_data;
        end else if (r_rs2 != '0 && fwd_wb_en && fwd_wb_rd == r_rs2) begin
            w_rs2_opnd = fwd_wb_data;
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_mem_en, fwd_wb_en, fwd_mem_rd, fwd_wb_rd,
                            fwd_mem_data, fwd_wb_data, r_rs1, r_rs2};
    assign w_rs1_opnd   = r_rs1_val;
    assign w_rs2_opnd   = r_rs2_val;
`endif

    assign alu_a     = w_rs1_opnd;
    assign alu_b     = r_use_imm ? r_imm : w_rs2_opnd;
    assign alu_f     = r_f;
    assign out_rd    = r_rd;
    assign out_wb_en = r_wb_en;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameters SHALL be: LENGTH, 32, datapath width; REG_BITS, 5, register-index width.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream (decode) entry present.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 in_rs1_val, in_rs2_val, in_imm  input  LENGTH each  register-file operands and immediate.
REQ-007 in_rs1, in_rs2, in_rd  input  REG_BITS each  source and destination indices.
REQ-008 in_use_imm, in_f, in_wb_en  input  1 each  B-select immediate, ALU function (0 ADD, 1 LUI), writeback enable.
REQ-009 flush  input  1  discard the held entry and any entry offered this cycle.
REQ-010 fwd_mem_en, fwd_wb_en  input  1 each  bypass sources valid.
REQ-011 fwd_mem_rd, fwd_wb_rd  input  REG_BITS each  bypass destination indices.
REQ-012 fwd_mem_data, fwd_wb_data  input  LENGTH each  bypass values.
REQ-013 alu_a, alu_b  output  LENGTH each  operands driving the ALU A and B inputs.
REQ-014 alu_f  output  1  ALU function select.
REQ-015 out_rd  output  REG_BITS; out_wb_en  output  1  forwarded with the entry.
REQ-016 out_valid  output  1; out_ready  input  1  downstream handshake.

Function
REQ-017 Stage SHALL hold exactly one entry; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-019 Accept SHALL occur when in_valid && in_ready; the entry is registered at that clock edge and appears on outputs the next cycle (latency 1).
REQ-020 EMPTY->FULL on accept; FULL->EMPTY when out_ready && !accept; FULL->FULL when out_ready && accept (back-to-back, throughput 1/cycle) or when !out_ready (hold, all registered fields unchanged).
REQ-021 flush SHALL force the next state to EMPTY regardless of in_valid/out_ready; flush has priority over accept and hold.
REQ-022 alu_b base value SHALL be in_imm when in_use_imm=1, else the rs2 value; selection is captured at accept.
REQ-023 alu_a SHALL be based on the registered rs1 value; alu_f, out_rd, out_wb_en SHALL be the registered fields.
REQ-024 Bypass (when compiled in) SHALL be combinational on the held indices every cycle, so a stalled entry picks up results that arrive during the stall.
REQ-025 Bypass priority: MEM over WB over registered value; index 0 SHALL never be bypassed; alu_b immediate SHALL never be bypassed.
REQ-026 Bypass match SHALL require fwd_x_en=1 and fwd_x_rd equal to the held source index.
REQ-027 When out_valid=0, alu_a, alu_b, alu_f, out_rd, out_wb_en SHALL be driven from the last registered values (reset values if none), and consumers SHALL ignore them.

Reset
REQ-028 rst_n=0 SHALL immediately set out_valid=0 and all registered fields (operands, immediate, indices, alu_f, out_wb_en, use_imm) to 0, independent of clk.
REQ-029 Reset asserted mid-stall SHALL drop the held entry; first accept after rst_n deasserts SHALL be the first clock edge with in_valid=1.

Configuration
REQ-030 Macro ALU_OPERAND_FORWARDING_EN defined: bypass per REQ-024..026 is present.
REQ-031 Macro undefined: fwd_* ports SHALL remain in the port list but be ignored; alu_a/alu_b SHALL be purely the registered values.

Verification
REQ-032 Reset: rst_n=0 with in_valid=1 -> out_valid=0, alu_a=alu_b=0 asynchronously; after release first accept yields out_valid=1 next cycle.
REQ-033 Stream: 4 back-to-back entries with out_ready=1, in_rs1_val=1..4, in_use_imm=0 -> alu_a=1,2,3,4 on consecutive cycles, in_ready constantly 1.
REQ-034 Stall: FULL with out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next entry appears following cycle, none lost.
REQ-035 Bypass (EN defined): held rs1=5, rs2=5; fwd_mem(rd=5, 0xAAAA) and fwd_wb(rd=5, 0xBBBB) -> alu_a=alu_b=0xAAAA; fwd_mem_en=0 -> 0xBBBB; rs1=0 with fwd rd=0 -> registered value.
REQ-036 Immediate: in_use_imm=1, in_imm=0x12345000, in_f=1, rs2 matching fwd_mem -> alu_b=0x12345000, alu_f=1.
REQ-037 Flush: flush=1 while FULL and in_valid=1 -> in_ready=0, out_valid=0 next cycle; no entry from that cycle appears.
